// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RSP,
        ST_DONE
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam logic [63:0] ALIGN_MASK      = 64'h7;

    function automatic logic is_misaligned(input logic [63:0] addr);
        return (addr & ALIGN_MASK) != '0;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/response channel between the MEM stage and memory.
interface mem_stage_ctrl_if;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );

endinterface

// File: rtl/mem_stage_ctrl_reg.sv
// Enabled register with synchronous active-high reset, used for MEM/WB data fields.
module mem_stage_ctrl_reg #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: launches data-memory requests, stalls the pipeline
// until the response or timeout, and produces the MEM/WB write-back fields.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   EXMEM_MemWrite,
    input  logic                   EXMEM_Mem2Reg,
    input  logic                   EXMEM_RegWrite,
    input  logic                   EXMEM_BL,
    input  logic [4:0]             EXMEM_Rd,
    input  logic [63:0]            EXMEM_ALU_out,
    input  logic [63:0]            EXMEM_datamem_write_data,
    input  logic [63:0]            EXMEM_PC_p4,
    mem_stage_ctrl_if.master       mem_if,
    output logic                   mem_stall,
    output logic                   mem_fault,
    output logic                   MEMWB_RegWrite,
    output logic [4:0]             MEMWB_Rd,
    output logic [63:0]            MEMWB_wb_data
);

    localparam int unsigned      CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic             r_regwrite;
    logic             r_bl;
    logic             r_fault;
    logic             r_memwb_regwrite;
    logic [4:0]       r_rd;
    logic [63:0]      r_addr;
    logic [63:0]      r_wdata;
    logic [63:0]      r_pc_p4;
    logic [63:0]      r_rdata;

    logic             w_mem_op;
    logic             w_misaligned;
    logic             w_launch;
    logic             w_timeout;
    logic             w_wb_en;
    logic [4:0]       w_wb_rd;
    logic [63:0]      w_wb_data;

    assign w_mem_op     = EXMEM_MemWrite | EXMEM_Mem2Reg;
    assign w_misaligned = w_mem_op && is_misaligned(EXMEM_ALU_out);
    assign w_launch     = (r_state == ST_IDLE) && w_mem_op && !w_misaligned;
    assign w_timeout    = (r_state == ST_WAIT_RSP) && !mem_if.mem_rsp_valid && (r_cnt == CNT_LAST);

    assign mem_stall = w_launch || (r_state == ST_REQ) || (r_state == ST_WAIT_RSP);
    assign mem_fault = ((r_state == ST_IDLE) && w_misaligned) || w_timeout;

    assign mem_if.mem_req_valid = (r_state == ST_REQ);
    assign mem_if.mem_we        = r_we;
    assign mem_if.mem_addr      = r_addr;
    assign mem_if.mem_wdata     = r_wdata;
    assign MEMWB_RegWrite       = r_memwb_regwrite;

    // Data fields only move on a real write-back; bubbles update RegWrite alone.
    always_comb begin
        w_wb_en   = 1'b0;
        w_wb_rd   = EXMEM_Rd;
        w_wb_data = EXMEM_BL ? EXMEM_PC_p4 : EXMEM_ALU_out;
        if (r_state == ST_IDLE) begin
            w_wb_en = !w_mem_op;
        end else if (r_state == ST_DONE) begin
            w_wb_en   = 1'b1;
            w_wb_rd   = r_rd;
            w_wb_data = r_bl ? r_pc_p4 : (r_we ? r_addr : r_rdata);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_we             <= 1'b0;
            r_regwrite       <= 1'b0;
            r_bl             <= 1'b0;
            r_fault          <= 1'b0;
            r_memwb_regwrite <= 1'b0;
            r_rd             <= '0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_pc_p4          <= '0;
            r_rdata          <= '0;
        end else begin
            r_memwb_regwrite <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_mem_op) begin
                        r_memwb_regwrite <= EXMEM_RegWrite;
                    end else if (!w_misaligned) begin
                        r_we       <= EXMEM_MemWrite;
                        r_regwrite <= EXMEM_RegWrite & ~EXMEM_MemWrite;
                        r_bl       <= EXMEM_BL;
                        r_rd       <= EXMEM_Rd;
                        r_addr     <= EXMEM_ALU_out;
                        r_wdata    <= EXMEM_datamem_write_data;
                        r_pc_p4    <= EXMEM_PC_p4;
                        r_fault    <= 1'b0;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_if.mem_req_ready) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (mem_if.mem_rsp_valid) begin
                        r_rdata <= mem_if.mem_rdata;
                        r_state <= ST_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_fault <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_memwb_regwrite <= r_regwrite & ~r_fault;
                    r_state          <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    mem_stage_ctrl_reg #(.WIDTH(5)) u_memwb_rd (
        .clk   (clk),
        .reset (reset),
        .en    (w_wb_en),
        .d     (w_wb_rd),
        .q     (MEMWB_Rd)
    );

    mem_stage_ctrl_reg #(.WIDTH(64)) u_memwb_wb_data (
        .clk   (clk),
        .reset (reset),
        .en    (w_wb_en),
        .d     (w_wb_data),
        .q     (MEMWB_wb_data)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (TIMEOUT=4).
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        EXMEM_MemWrite, EXMEM_Mem2Reg, EXMEM_RegWrite, EXMEM_BL;
    logic [4:0]  EXMEM_Rd;
    logic [63:0] EXMEM_ALU_out, EXMEM_datamem_write_data, EXMEM_PC_p4;
    logic        mem_stall, mem_fault, MEMWB_RegWrite;
    logic [4:0]  MEMWB_Rd;
    logic [63:0] MEMWB_wb_data;

    int n_checks = 0;
    int n_err    = 0;
    int stall_cnt;

    mem_stage_ctrl_if mem_if ();

    mem_stage_ctrl #(.TIMEOUT(4)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .EXMEM_MemWrite           (EXMEM_MemWrite),
        .EXMEM_Mem2Reg            (EXMEM_Mem2Reg),
        .EXMEM_RegWrite           (EXMEM_RegWrite),
        .EXMEM_BL                 (EXMEM_BL),
        .EXMEM_Rd                 (EXMEM_Rd),
        .EXMEM_ALU_out            (EXMEM_ALU_out),
        .EXMEM_datamem_write_data (EXMEM_datamem_write_data),
        .EXMEM_PC_p4              (EXMEM_PC_p4),
        .mem_if                   (mem_if),
        .mem_stall                (mem_stall),
        .mem_fault                (mem_fault),
        .MEMWB_RegWrite           (MEMWB_RegWrite),
        .MEMWB_Rd                 (MEMWB_Rd),
        .MEMWB_wb_data            (MEMWB_wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic mw, input logic m2r, input logic rw, input logic bl,
                          input logic [4:0] rd, input logic [63:0] alu,
                          input logic [63:0] wd, input logic [63:0] pc);
        EXMEM_MemWrite = mw; EXMEM_Mem2Reg = m2r; EXMEM_RegWrite = rw; EXMEM_BL = bl;
        EXMEM_Rd = rd; EXMEM_ALU_out = alu; EXMEM_datamem_write_data = wd; EXMEM_PC_p4 = pc;
    endtask

    task automatic set_nop();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0);
    endtask

    initial begin
        reset = 1'b1;
        set_nop();
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rdata     = 64'h0;
        tick();
        tick();
        chk("rst_regwrite", MEMWB_RegWrite, 1'b0);
        chk("rst_rd", MEMWB_Rd, 5'd0);
        chk("rst_wbdata", MEMWB_wb_data, 64'h0);
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_fault", mem_fault, 1'b0);
        chk("rst_reqvalid", mem_if.mem_req_valid, 1'b0);
        reset = 1'b0;

        // ALU op: write-back next edge, no stall
        set_ex(1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 64'h10, 64'h0, 64'h0);
        #1;
        chk("add_stall", mem_stall, 1'b0);
        chk("add_reqvalid", mem_if.mem_req_valid, 1'b0);
        tick();
        chk("add_regwrite", MEMWB_RegWrite, 1'b1);
        chk("add_rd", MEMWB_Rd, 5'd3);
        chk("add_wbdata", MEMWB_wb_data, 64'h10);

        // BL selects PC+4
        set_ex(1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 64'h99, 64'h0, 64'h104);
        tick();
        chk("bl_rd", MEMWB_Rd, 5'd31);
        chk("bl_wbdata", MEMWB_wb_data, 64'h104);
        set_nop();
        tick();
        chk("nop_regwrite", MEMWB_RegWrite, 1'b0);

        // Load 0x40: ready on 2nd REQ cycle, response on 3rd WAIT cycle
        stall_cnt = 0;
        set_ex(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 64'h40, 64'h0, 64'h0);
        #1;
        chk("ld_launch_stall", mem_stall, 1'b1);
        chk("ld_launch_reqvalid", mem_if.mem_req_valid, 1'b0);
        stall_cnt += int'(mem_stall);
        tick();
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rdata     = 64'hBAD;
        #1;
        chk("ld_req1_valid", mem_if.mem_req_valid, 1'b1);
        chk("ld_req1_addr", mem_if.mem_addr, 64'h40);
        chk("ld_req1_we", mem_if.mem_we, 1'b0);
        stall_cnt += int'(mem_stall);
        tick();
        chk("ld_bubble", MEMWB_RegWrite, 1'b0);
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_req_ready = 1'b1;
        #1;
        chk("ld_req2_valid", mem_if.mem_req_valid, 1'b1);
        stall_cnt += int'(mem_stall);
        tick();
        mem_if.mem_req_ready = 1'b0;
        #1;
        chk("ld_wait_reqvalid", mem_if.mem_req_valid, 1'b0);
        stall_cnt += int'(mem_stall);
        tick();
        stall_cnt += int'(mem_stall);
        tick();
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rdata     = 64'hDEAD;
        #1;
        stall_cnt += int'(mem_stall);
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        #1;
        chk("ld_stall_cycles", stall_cnt, 6);
        chk("ld_done_stall", mem_stall, 1'b0);
        chk("ld_done_fault", mem_fault, 1'b0);
        tick();
        set_nop();
        chk("ld_regwrite", MEMWB_RegWrite, 1'b1);
        chk("ld_rd", MEMWB_Rd, 5'd5);
        chk("ld_wbdata", MEMWB_wb_data, 64'hDEAD);

        // Store (MemWrite and Mem2Reg both set): immediate ready and ack
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 64'h48, 64'h55, 64'h0);
        mem_if.mem_req_ready = 1'b1;
        #1;
        chk("st_launch_stall", mem_stall, 1'b1);
        tick();
        chk("st_req_valid", mem_if.mem_req_valid, 1'b1);
        chk("st_we", mem_if.mem_we, 1'b1);
        chk("st_addr", mem_if.mem_addr, 64'h48);
        chk("st_wdata", mem_if.mem_wdata, 64'h55);
        tick();
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b1;
        #1;
        chk("st_wait_fault", mem_fault, 1'b0);
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        #1;
        chk("st_done_stall", mem_stall, 1'b0);
        tick();
        set_nop();
        chk("st_regwrite", MEMWB_RegWrite, 1'b0);

        // Misaligned load 0x43: fault pulse, no request, no stall
        set_ex(1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 64'h43, 64'h0, 64'h0);
        #1;
        chk("mis_fault", mem_fault, 1'b1);
        chk("mis_stall", mem_stall, 1'b0);
        chk("mis_reqvalid", mem_if.mem_req_valid, 1'b0);
        tick();
        set_nop();
        #1;
        chk("mis_regwrite", MEMWB_RegWrite, 1'b0);
        chk("mis_fault_gone", mem_fault, 1'b0);
        chk("mis_reqvalid_after", mem_if.mem_req_valid, 1'b0);

        // Timeout: no response for 4 WAIT_RSP cycles
        set_ex(1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 64'h80, 64'h0, 64'h0);
        mem_if.mem_req_ready = 1'b1;
        tick();
        tick();
        mem_if.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("to_early_fault", mem_fault, 1'b0);
            chk("to_wait_stall", mem_stall, 1'b1);
            tick();
        end
        #1;
        chk("to_fault", mem_fault, 1'b1);
        tick();
        chk("to_done_fault", mem_fault, 1'b0);
        chk("to_done_stall", mem_stall, 1'b0);
        tick();
        set_nop();
        chk("to_regwrite", MEMWB_RegWrite, 1'b0);

        // Response in the same cycle the timeout would fire: response wins
        set_ex(1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 64'h88, 64'h0, 64'h0);
        mem_if.mem_req_ready = 1'b1;
        tick();
        tick();
        mem_if.mem_req_ready = 1'b0;
        tick();
        tick();
        tick();
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rdata     = 64'h1234;
        #1;
        chk("race_fault", mem_fault, 1'b0);
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        tick();
        set_nop();
        chk("race_regwrite", MEMWB_RegWrite, 1'b1);
        chk("race_rd", MEMWB_Rd, 5'd6);
        chk("race_wbdata", MEMWB_wb_data, 64'h1234);

        // Reset during WAIT_RSP, then a stray response
        set_ex(1'b0, 1'b1, 1'b1, 1'b0, 5'd8, 64'h90, 64'h0, 64'h0);
        mem_if.mem_req_ready = 1'b1;
        tick();
        tick();
        mem_if.mem_req_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_nop();
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rdata     = 64'hFFFF;
        #1;
        chk("rstw_stall", mem_stall, 1'b0);
        chk("rstw_fault", mem_fault, 1'b0);
        chk("rstw_reqvalid", mem_if.mem_req_valid, 1'b0);
        chk("rstw_we", mem_if.mem_we, 1'b0);
        chk("rstw_addr", mem_if.mem_addr, 64'h0);
        chk("rstw_rd", MEMWB_Rd, 5'd0);
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        chk("rstw_regwrite", MEMWB_RegWrite, 1'b0);
        chk("rstw_wbdata", MEMWB_wb_data, 64'h0);
        chk("rstw_stall_after", mem_stall, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
